// File: rtl/instruction_fetch.sv
// Instruction-fetch stage with a small in-order prefetch FIFO and the IF/ID
// pipeline register; redirects flush the front end and drop stale responses.

module instruction_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] PC_1,
    output logic        if_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] drop_r;
    logic [CW-1:0] fifo_count_r;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [63:0]   fifo_mem_r [DEPTH];
    logic [31:0]   instruction_r;
    logic [31:0]   pc_1_r;
    logic          if_valid_r;

    logic [CW:0]   inflight_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;

    // Issue cap counts both buffered and in-flight words so the FIFO can never overflow
    always_comb begin
        inflight_s  = {1'b0, fifo_count_r} + {1'b0, outstanding_r};
        req_valid_s = !reset && !redirect && (inflight_s < DEPTH_W);
        req_fire_s  = req_valid_s && imem_req_ready;
        push_s      = imem_rsp_valid && !redirect && (drop_r == {CW{1'b0}});
        pop_s       = !redirect && !stall && (fifo_count_r != {CW{1'b0}});
    end

    // Fetch/response PCs and the outstanding/drop bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= {CW{1'b0}};
            drop_r        <= {CW{1'b0}};
        end else begin
            case ({req_fire_s, imem_rsp_valid})
                2'b10:   outstanding_r <= outstanding_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   outstanding_r <= outstanding_r - {{(CW-1){1'b0}}, 1'b1};
                default: outstanding_r <= outstanding_r;
            endcase
            if (redirect) begin
                fetch_pc_r <= redirect_pc;
                rsp_pc_r   <= redirect_pc;
                // Everything still in flight is stale; a response landing now is dropped too
                drop_r     <= outstanding_r - {{(CW-1){1'b0}}, imem_rsp_valid};
            end else begin
                if (req_fire_s) begin
                    fetch_pc_r <= fetch_pc_r + 32'd1;
                end else begin
                    fetch_pc_r <= fetch_pc_r;
                end
                if (imem_rsp_valid && (drop_r != {CW{1'b0}})) begin
                    drop_r <= drop_r - {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    drop_r <= drop_r;
                end
                if (push_s) begin
                    rsp_pc_r <= rsp_pc_r + 32'd1;
                end else begin
                    rsp_pc_r <= rsp_pc_r;
                end
            end
        end
    end

    // Prefetch FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            fifo_count_r <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, push_s};
            rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   fifo_count_r <= fifo_count_r - {{(CW-1){1'b0}}, 1'b1};
                default: fifo_count_r <= fifo_count_r;
            endcase
        end
    end

    // FIFO storage: {instruction word, its address + 1}
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {imem_rsp_data, rsp_pc_r + 32'd1};
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // IF/ID register: redirect beats stall, stall beats pop, empty inserts a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_r <= 32'h0000_0000;
            pc_1_r        <= 32'h0000_0000;
            if_valid_r    <= 1'b0;
        end else if (redirect) begin
            instruction_r <= 32'h0000_0000;
            pc_1_r        <= pc_1_r;
            if_valid_r    <= 1'b0;
        end else if (stall) begin
            instruction_r <= instruction_r;
            pc_1_r        <= pc_1_r;
            if_valid_r    <= if_valid_r;
        end else if (pop_s) begin
            instruction_r <= fifo_mem_r[rd_ptr_r][63:32];
            pc_1_r        <= fifo_mem_r[rd_ptr_r][31:0];
            if_valid_r    <= 1'b1;
        end else begin
            instruction_r <= 32'h0000_0000;
            pc_1_r        <= pc_1_r;
            if_valid_r    <= 1'b0;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign instruction    = instruction_r;
    assign PC_1           = pc_1_r;
    assign if_valid       = if_valid_r;

    instruction_fetch_checker #(.DEPTH(DEPTH)) u_checker (
        .clk          (clk),
        .reset        (reset),
        .push         (push_s),
        .fifo_count   (fifo_count_r),
        .outstanding  (outstanding_r)
    );

endmodule

// Invariants of the prefetch FIFO and the request cap.
module instruction_fetch_checker #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    input  logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int CW = $clog2(DEPTH + 1);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (fifo_count == CW'(DEPTH))));

    a_inflight_capped: assert property (@(posedge clk) disable iff (reset)
        (({1'b0, fifo_count} + {1'b0, outstanding}) <= (CW + 1)'(DEPTH)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fill, stall, redirect, redirect+stall,
// memory backpressure, and PC wrap from RESET_PC = 32'hFFFF_FFFF.

module tb_instruction_fetch;

    localparam logic [31:0] MEM_BASE = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_ready;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    int          lat;
    int          checks_cnt = 0;
    int          fail_cnt = 0;

    logic        req_valid, rsp_valid, if_valid;
    logic [31:0] req_addr, rsp_data, instruction, pc_1;
    logic [1:0]  pv_r;
    logic [31:0] pd_r [2];

    logic        req2_valid, if2_valid;
    logic [31:0] req2_addr, instruction2, pc2_1;
    logic        pv2_r;
    logic [31:0] pd2_r;

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .instruction(instruction), .PC_1(pc_1), .if_valid(if_valid)
    );

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(req2_valid), .imem_req_ready(1'b1), .imem_req_addr(req2_addr),
        .imem_rsp_valid(pv2_r), .imem_rsp_data(pd2_r),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .instruction(instruction2), .PC_1(pc2_1), .if_valid(if2_valid)
    );

    // Memory with latency 1 or 2 cycles, mem[a] = A000_0000 + a
    always @(posedge clk) begin
        if (reset) begin
            pv_r <= 2'b00;
        end else begin
            pv_r[1]  <= pv_r[0];
            pv_r[0]  <= req_valid && imem_req_ready;
            pd_r[1]  <= pd_r[0];
            pd_r[0]  <= MEM_BASE + req_addr;
        end
    end
    assign rsp_valid = (lat == 1) ? pv_r[0] : pv_r[1];
    assign rsp_data  = (lat == 1) ? pd_r[0] : pd_r[1];

    // Single-cycle memory for the wrap instance
    always @(posedge clk) begin
        if (reset) begin
            pv2_r <= 1'b0;
        end else begin
            pv2_r <= req2_valid;
            pd2_r <= MEM_BASE + req2_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int latency);
        lat            = latency;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_instr", instruction, 32'h0);
        check_eq("rst_pc1", pc_1, 32'h0);
        check_eq("rst_valid", {31'h0, if_valid}, 32'h0);
        check_eq("rst_req_valid", {31'h0, req_valid}, 32'h0);
        check_eq("rst_req_addr", req_addr, 32'h0);
        check_eq("rst_wrap_addr", req2_addr, 32'hFFFF_FFFF);
        reset = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!if_valid && n < 20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;

        // Fill from reset with single-cycle memory
        do_reset(1);
        tick();
        check_eq("e1_valid", {31'h0, if_valid}, 32'h0);
        check_eq("e1_addr", req_addr, 32'h1);
        check_eq("wrap_addr2", req2_addr, 32'h0);
        tick();
        check_eq("e2_valid", {31'h0, if_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("fill_instr", instruction, MEM_BASE + 32'(k));
            check_eq("fill_pc1", pc_1, 32'(k + 1));
            check_eq("fill_valid", {31'h0, if_valid}, 32'h1);
            if (k == 0) begin
                check_eq("wrap_instr0", instruction2, 32'h9FFF_FFFF);
                check_eq("wrap_pc1_0", pc2_1, 32'h0);
                check_eq("wrap_valid0", {31'h0, if2_valid}, 32'h1);
            end
            if (k == 1) begin
                check_eq("wrap_instr1", instruction2, MEM_BASE);
                check_eq("wrap_pc1_1", pc2_1, 32'h1);
            end
        end

        // Stall for 5 cycles: outputs frozen, prefetch stops at the cap
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("stall_instr", instruction, MEM_BASE + 32'h2);
            check_eq("stall_pc1", pc_1, 32'h3);
            check_eq("stall_valid", {31'h0, if_valid}, 32'h1);
            check_eq("stall_req_valid", {31'h0, req_valid}, (k == 0) ? 32'h1 : 32'h0);
        end
        stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("post_stall_instr", instruction, MEM_BASE + 32'(k + 3));
            check_eq("post_stall_pc1", pc_1, 32'(k + 4));
            check_eq("post_stall_valid", {31'h0, if_valid}, 32'h1);
        end

        // Memory not ready: request held stable, FIFO drains into bubbles
        do_reset(1);
        repeat (5) tick();
        imem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("bp_req_valid", {31'h0, req_valid}, 32'h1);
            check_eq("bp_req_addr", req_addr, 32'h5);
            check_eq("bp_instr", instruction, (k < 2) ? MEM_BASE + 32'(k + 3) : 32'h0);
            check_eq("bp_valid", {31'h0, if_valid}, (k < 2) ? 32'h1 : 32'h0);
            check_eq("bp_pc1", pc_1, (k < 2) ? 32'(k + 4) : 32'h5);
        end
        imem_req_ready = 1'b1;
        wait_valid(n);
        check_eq("bp_resume_lat", 32'(n), 32'h3);
        check_eq("bp_resume_instr", instruction, MEM_BASE + 32'h5);
        check_eq("bp_resume_pc1", pc_1, 32'h6);

        // Redirect with two requests outstanding (2-cycle memory)
        do_reset(2);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check_eq("redir_req_valid", {31'h0, req_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        check_eq("redir_bubble", instruction, 32'h0);
        check_eq("redir_valid", {31'h0, if_valid}, 32'h0);
        check_eq("redir_addr", req_addr, 32'h40);
        wait_valid(n);
        check_eq("redir_lat", 32'(n), 32'h4);
        check_eq("redir_instr", instruction, MEM_BASE + 32'h40);
        check_eq("redir_pc1", pc_1, 32'h41);
        tick();
        check_eq("redir_instr2", instruction, MEM_BASE + 32'h41);
        check_eq("redir_pc1_2", pc_1, 32'h42);

        // Redirect and stall together: flush wins
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check_eq("rs_instr", instruction, 32'h0);
        check_eq("rs_valid", {31'h0, if_valid}, 32'h0);
        check_eq("rs_pc1", pc_1, 32'h42);
        #1;
        check_eq("rs_req_valid", {31'h0, req_valid}, 32'h1);
        check_eq("rs_req_addr", req_addr, 32'h100);
        tick();
        check_eq("rs_hold_valid", {31'h0, if_valid}, 32'h0);
        stall = 1'b0;
        wait_valid(n);
        check_eq("rs_lat", 32'(n), 32'h3);
        check_eq("rs_instr_first", instruction, MEM_BASE + 32'h100);
        check_eq("rs_pc1_first", pc_1, 32'h101);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
